// File: rtl/lc3_pkg.sv
// Shared encodings and opcode classifiers for the LC3 pipeline control.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_state_e;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  // Instructions whose base/first source register sits in bits 8:6.
  function automatic logic reads_sr1(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
           (op == OP_LDR) || (op == OP_STR) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/lc3_dep_check.sv
// Register dependency check between the decode and execute instructions.
module lc3_dep_check
  import lc3_pkg::*;
(
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic        exec_valid,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        load_use
);

  logic [3:0] op_d;
  logic [3:0] op_x;
  logic [2:0] dr_x;
  logic       sr1_hit;
  logic       sr2_hit;
  logic       st_hit;
  logic       unused_bits;

  assign op_d        = IR[15:12];
  assign op_x        = IR_Exec[15:12];
  assign dr_x        = IR_Exec[11:9];
  assign unused_bits = ^{IR[4:3], IR_Exec[8:0]};

  // Source-register matches against the execute-stage destination; bubbles never match.
  always_comb begin
    sr1_hit      = reads_sr1(op_d) && (dr_x == IR[8:6]);
    sr2_hit      = ((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5] && (dr_x == IR[2:0]);
    st_hit       = is_store(op_d) && (dr_x == IR[11:9]);
    bypass_alu_1 = exec_valid && is_alu(op_x) && sr1_hit;
    bypass_alu_2 = exec_valid && is_alu(op_x) && (sr2_hit || st_hit);
    load_use     = exec_valid && is_load(op_x) && (sr1_hit || sr2_hit || st_hit);
  end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// Pipeline controller: memory sequencer, branch counter and stage enables.
module lc3_pipe_ctrl
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        de_valid,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic [1:0]  mem_state
);

  mem_state_e mem_q;
  mem_state_e mem_d;
  logic [1:0] br_cnt;
  logic [1:0] br_cnt_d;
  logic       exec_valid;
  logic       byp1;
  logic       byp2;
  logic       load_use;
  logic       mem_stall;
  logic       fetch_ctrl;
  logic       br_hit;
  logic [3:0] op_x;
  logic       unused_imem;

  assign op_x        = IR_Exec[15:12];
  assign mem_state   = mem_q;
  assign mem_stall   = (mem_q != MEM_IDLE);
  assign unused_imem = ^IMem_dout[11:0];
  // Only a fresh fetch starts a branch; while br_cnt runs the same word may still be on the bus.
  assign fetch_ctrl  = is_ctrl(IMem_dout[15:12]) && (br_cnt == 2'd0);
  assign br_hit      = (op_x == OP_JMP) || ((op_x == OP_BR) && ((NZP & psr) != 3'b000));

  lc3_dep_check u_dep (
    .IR           (IR),
    .IR_Exec      (IR_Exec),
    .exec_valid   (exec_valid),
    .bypass_alu_1 (byp1),
    .bypass_alu_2 (byp2),
    .load_use     (load_use)
  );

  // State register; exec_valid mirrors what the Decode->Execute register captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= MEM_IDLE;
      br_cnt     <= '0;
      exec_valid <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      br_cnt     <= br_cnt_d;
      exec_valid <= de_valid;
    end
  end

  // Memory sequencer next state.
  always_comb begin
    mem_d = mem_q;
    unique case (mem_q)
      MEM_IDLE: begin
        if (exec_valid && enable_execute) begin
          case (op_x)
            OP_LD, OP_LDR:  mem_d = MEM_RD;
            OP_LDI, OP_STI: mem_d = MEM_IND;
            OP_ST, OP_STR:  mem_d = MEM_WR;
            default:        mem_d = MEM_IDLE;
          endcase
        end
      end
      MEM_IND: if (complete_data) mem_d = (op_x == OP_LDI) ? MEM_RD : MEM_WR;
      MEM_RD:  if (complete_data) mem_d = MEM_IDLE;
      MEM_WR:  if (complete_data) mem_d = MEM_IDLE;
      default: mem_d = MEM_IDLE;
    endcase
  end

  // Stage enables in priority order: reset, memory stall, load-use, branch, normal.
  always_comb begin
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    de_valid         = 1'b0;
    br_taken         = 1'b0;
    bypass_alu_1     = 1'b0;
    bypass_alu_2     = 1'b0;
    if (reset) begin
      enable_writeback = 1'b0;
    end else if (mem_stall) begin
      enable_writeback = (mem_q == MEM_RD) && complete_data;
    end else if (load_use) begin
      enable_execute   = 1'b1;
      enable_writeback = 1'b1;
    end else begin
      enable_updatePC  = !(fetch_ctrl || (br_cnt == 2'd2));
      enable_fetch     = complete_instr;
      enable_decode    = 1'b1;
      enable_execute   = 1'b1;
      enable_writeback = 1'b1;
      de_valid         = (br_cnt != 2'd1);
      br_taken         = (br_cnt == 2'd1) && br_hit;
    end
    if (!reset) begin
      bypass_alu_1 = byp1;
      bypass_alu_2 = byp2;
    end
  end

  // Branch counter: load on a recognised control fetch, count down on unstalled cycles.
  always_comb begin
    br_cnt_d = br_cnt;
    if (enable_decode && fetch_ctrl)
      br_cnt_d = 2'd2;
    else if (!mem_stall && !load_use && (br_cnt != 2'd0))
      br_cnt_d = br_cnt - 2'd1;
  end

endmodule
